rv32_dmem_arbiter: RTL and testbench

- Shares the single data-memory macro between two requesters: the barreled core LSU (requester 0) and the host/debug loader (requester 1).
- The memory has one write port and one read port, so write traffic and read traffic are arbitrated independently. One read and one write may issue in the same cycle.
- Core has fixed priority. A per-port starvation counter guarantees the host forward progress.
- Sits between the LSU/host bus adapters and rv32_data_memory. Its mem_* outputs connect directly to the memory's data/rdaddress/wraddress/wren/q.

---
 rtl/rv32_dmem_arbiter.sv | 108 ++++++++++
 tb/tb_rv32_dmem_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_dmem_arbiter.sv
// Two-requester (core LSU, host loader) arbiter for the single data-memory macro.
// Optional same-cycle write-to-read forwarding is enabled by defining DMEM_ARB_FWD_EN.
module rv32_dmem_arbiter #(
   parameter int unsigned ADDR_W   = 13,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic              clock,
   input  logic              rst_n,
   input  logic              core_req,
   input  logic              core_we,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [DATA_W-1:0] core_wdata,
   output logic              core_gnt,
   output logic              core_rvalid,
   output logic [DATA_W-1:0] core_rdata,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic              host_gnt,
   output logic              host_rvalid,
   output logic [DATA_W-1:0] host_rdata,
   output logic [DATA_W-1:0] mem_data,
   output logic [ADDR_W-1:0] mem_wraddress,
   output logic              mem_wren,
   output logic [ADDR_W-1:0] mem_rdaddress,
   input  logic [DATA_W-1:0] mem_q
);

   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

   logic             core_wr_cand, host_wr_cand, core_rd_cand, host_rd_cand;
   logic             core_wr_gnt, host_wr_gnt, core_rd_gnt, host_rd_gnt;
   logic [CNT_W-1:0] wr_wait, rd_wait, wr_wait_nxt, rd_wait_nxt;
   logic             rd_pend, rd_owner;
   logic [DATA_W-1:0] rd_data;

   // Independent fixed-priority arbitration per port; host wins once its wait saturates.
   always_comb begin
      core_wr_cand = rst_n & core_req & core_we;
      host_wr_cand = rst_n & host_req & host_we;
      core_rd_cand = rst_n & core_req & ~core_we;
      host_rd_cand = rst_n & host_req & ~host_we;

      host_wr_gnt = host_wr_cand & (~core_wr_cand | (wr_wait == WAIT_MAX));
      core_wr_gnt = core_wr_cand & ~host_wr_gnt;
      host_rd_gnt = host_rd_cand & (~core_rd_cand | (rd_wait == WAIT_MAX));
      core_rd_gnt = core_rd_cand & ~host_rd_gnt;

      wr_wait_nxt = '0;
      rd_wait_nxt = '0;
      if (host_wr_cand && !host_wr_gnt)
         wr_wait_nxt = (wr_wait == WAIT_MAX) ? wr_wait : wr_wait + CNT_W'(1);
      if (host_rd_cand && !host_rd_gnt)
         rd_wait_nxt = (rd_wait == WAIT_MAX) ? rd_wait : rd_wait + CNT_W'(1);
   end

   assign core_gnt = core_wr_gnt | core_rd_gnt;
   assign host_gnt = host_wr_gnt | host_rd_gnt;

   // Memory-side steering; idle write port carries the core's values, all zero in reset.
   assign mem_wren      = core_wr_gnt | host_wr_gnt;
   assign mem_wraddress = !rst_n ? '0 : (host_wr_gnt ? host_addr  : core_addr);
   assign mem_data      = !rst_n ? '0 : (host_wr_gnt ? host_wdata : core_wdata);
   assign mem_rdaddress = !rst_n ? '0 : (host_rd_gnt ? host_addr  : core_addr);

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         wr_wait  <= '0;
         rd_wait  <= '0;
         rd_pend  <= 1'b0;
         rd_owner <= 1'b0;
      end else begin
         wr_wait  <= wr_wait_nxt;
         rd_wait  <= rd_wait_nxt;
         rd_pend  <= core_rd_gnt | host_rd_gnt;
         rd_owner <= host_rd_gnt;
      end
   end

`ifdef DMEM_ARB_FWD_EN
   logic              fwd;
   logic [DATA_W-1:0] fwd_data;

   // Same-cycle same-address read/write returns the freshly written word.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         fwd      <= 1'b0;
         fwd_data <= '0;
      end else begin
         fwd      <= (core_rd_gnt | host_rd_gnt) & mem_wren & (mem_rdaddress == mem_wraddress);
         fwd_data <= mem_data;
      end
   end

   assign rd_data = fwd ? fwd_data : mem_q;
`else
   assign rd_data = mem_q;
`endif

   assign core_rvalid = rd_pend & ~rd_owner;
   assign host_rvalid = rd_pend & rd_owner;
   assign core_rdata  = core_rvalid ? rd_data : '0;
   assign host_rdata  = host_rvalid ? rd_data : '0;

endmodule

// File: tb/tb_rv32_dmem_arbiter.sv
// Self-checking bench for rv32_dmem_arbiter: directed scenarios plus constrained-random
// traffic against a shadow-memory/queue reference model. Honours DMEM_ARB_FWD_EN.
module tb_rv32_dmem_arbiter;
   localparam int unsigned ADDR_W   = 13;
   localparam int unsigned DATA_W   = 32;
   localparam int unsigned MAX_WAIT = 4;

   logic              clock = 1'b0;
   logic              rst_n = 1'b0;
   logic              core_req = 1'b0, core_we = 1'b0;
   logic [ADDR_W-1:0] core_addr = '0;
   logic [DATA_W-1:0] core_wdata = '0;
   logic              core_gnt, core_rvalid;
   logic [DATA_W-1:0] core_rdata;
   logic              host_req = 1'b0, host_we = 1'b0;
   logic [ADDR_W-1:0] host_addr = '0;
   logic [DATA_W-1:0] host_wdata = '0;
   logic              host_gnt, host_rvalid;
   logic [DATA_W-1:0] host_rdata;
   logic [DATA_W-1:0] mem_data, mem_q = '0;
   logic [ADDR_W-1:0] mem_wraddress, mem_rdaddress;
   logic              mem_wren;

   always #5 clock = ~clock;

   rv32_dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
      .clock(clock), .rst_n(rst_n),
      .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
      .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
      .mem_data(mem_data), .mem_wraddress(mem_wraddress), .mem_wren(mem_wren),
      .mem_rdaddress(mem_rdaddress), .mem_q(mem_q)
   );

   // Behavioural memory macro: 1-cycle read, read-before-write on collision.
   logic [DATA_W-1:0] ram [8192] = '{default: 32'h0};
   always @(posedge clock) begin
      if (mem_wren) ram[mem_wraddress] <= mem_data;
      mem_q <= ram[mem_rdaddress];
   end

   int total = 0, bad = 0;

   // Reference model state
   logic [DATA_W-1:0] shadow [8192] = '{default: 32'h0};
   int  m_wr_wait = 0, m_rd_wait = 0;
   bit  p_valid = 0, p_owner = 0, p_chk = 1;
   logic [DATA_W-1:0] p_data = '0;
   bit  e_cg, e_hg, obs_cg, obs_hg;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_wr_wait = 0; m_rd_wait = 0;
      p_valid = 0; p_owner = 0; p_chk = 1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_core_gnt"},    32'(core_gnt),      0);
      chk({tag, "_host_gnt"},    32'(host_gnt),      0);
      chk({tag, "_mem_wren"},    32'(mem_wren),      0);
      chk({tag, "_core_rvalid"}, 32'(core_rvalid),   0);
      chk({tag, "_host_rvalid"}, 32'(host_rvalid),   0);
      chk({tag, "_core_rdata"},  core_rdata,         0);
      chk({tag, "_host_rdata"},  host_rdata,         0);
      chk({tag, "_mem_wraddr"},  32'(mem_wraddress), 0);
      chk({tag, "_mem_rdaddr"},  32'(mem_rdaddress), 0);
      chk({tag, "_mem_data"},    mem_data,           0);
   endtask

   // One clock cycle: check the cycle against the model, cross the edge, advance the model.
   task automatic cycle();
      bit cw, hw, cr, hr, ewc, ewh, erc, erh;
      logic [ADDR_W-1:0] ra, wa;
      logic [DATA_W-1:0] wd;
      #1;
      cw = core_req && core_we;  hw = host_req && host_we;
      cr = core_req && !core_we; hr = host_req && !host_we;
      ewh = hw && (!cw || m_wr_wait == MAX_WAIT); ewc = cw && !ewh;
      erh = hr && (!cr || m_rd_wait == MAX_WAIT); erc = cr && !erh;
      e_cg = ewc || erc; e_hg = ewh || erh;
      obs_cg = core_gnt; obs_hg = host_gnt;
      wa = ewh ? host_addr : core_addr;
      wd = ewh ? host_wdata : core_wdata;
      ra = erh ? host_addr : core_addr;
      chk("core_gnt", 32'(core_gnt), 32'(e_cg));
      chk("host_gnt", 32'(host_gnt), 32'(e_hg));
      chk("mem_wren", 32'(mem_wren), 32'(ewc || ewh));
      chk("mem_wraddress", 32'(mem_wraddress), 32'(wa));
      chk("mem_data", mem_data, wd);
      chk("mem_rdaddress", 32'(mem_rdaddress), 32'(ra));
      chk("core_rvalid", 32'(core_rvalid), 32'(p_valid && !p_owner));
      chk("host_rvalid", 32'(host_rvalid), 32'(p_valid && p_owner));
      if (!(p_valid && !p_owner)) chk("core_rdata_idle", core_rdata, 0);
      else if (p_chk)             chk("core_rdata", core_rdata, p_data);
      if (!(p_valid && p_owner))  chk("host_rdata_idle", host_rdata, 0);
      else if (p_chk)             chk("host_rdata", host_rdata, p_data);
      @(posedge clock);
      p_valid = erc || erh; p_owner = erh; p_data = shadow[ra]; p_chk = 1;
      if ((erc || erh) && (ewc || ewh) && ra == wa) begin
`ifdef DMEM_ARB_FWD_EN
         p_data = wd;
`else
         p_chk = 0;
`endif
      end
      if (ewc || ewh) shadow[wa] = wd;
      m_wr_wait = (hw && !ewh) ? ((m_wr_wait + 1 > MAX_WAIT) ? MAX_WAIT : m_wr_wait + 1) : 0;
      m_rd_wait = (hr && !erh) ? ((m_rd_wait + 1 > MAX_WAIT) ? MAX_WAIT : m_rd_wait + 1) : 0;
      #1;
   endtask

   task automatic new_core();
      core_req   = ($urandom_range(0, 99) < 60);
      core_we    = 1'($urandom_range(0, 1));
      core_addr  = ADDR_W'($urandom_range(0, 7));
      core_wdata = $urandom;
   endtask

   task automatic new_host();
      host_req   = ($urandom_range(0, 99) < 75);
      host_we    = 1'($urandom_range(0, 1));
      host_addr  = ADDR_W'($urandom_range(0, 7));
      host_wdata = $urandom;
   endtask

   initial begin
      int hcnt;
      // Reset state
      repeat (2) @(posedge clock);
      #1;
      chk_reset_outputs("rst");
      @(negedge clock);
      rst_n = 1'b1;
      m_reset();
      #1;
      chk("rst_wr_wait", 32'(dut.wr_wait), 0);
      chk("rst_rd_wait", 32'(dut.rd_wait), 0);

      // Core write then read of 0x010
      core_req = 1; core_we = 1; core_addr = 13'h010; core_wdata = 32'hDEADBEEF;
      cycle();
      core_we = 0;
      cycle();
      core_req = 0;
      #1;
      chk("t1_core_rvalid", 32'(core_rvalid), 1);
      chk("t1_core_rdata", core_rdata, 32'hDEADBEEF);
      chk("t1_host_rvalid", 32'(host_rvalid), 0);
      cycle();

      // Continuous read contention: host wins every fifth cycle
      hcnt = 0;
      host_req = 1; host_we = 0; host_addr = 13'h050;
      core_req = 1; core_we = 0; core_addr = 13'h011;
      for (int i = 0; i < 20; i++) begin
         cycle();
         chk("starve_host_gnt", 32'(obs_hg), 32'(i % 5 == 4));
         if (obs_hg) begin
            hcnt++;
            chk("starve_rd_wait_clr", 32'(dut.rd_wait), 0);
         end
         if (e_cg) core_addr = ADDR_W'($urandom_range(0, 31));
      end
      chk("starve_host_count", 32'(hcnt), 4);
      core_req = 0; host_req = 0;
      cycle();

      // Preload 0x030, then core write 0x020 concurrent with host read 0x030
      host_req = 1; host_we = 1; host_addr = 13'h030; host_wdata = 32'h12345678;
      cycle();
      host_we = 0;
      core_req = 1; core_we = 1; core_addr = 13'h020; core_wdata = 32'hA5A5_0020;
      cycle();
      chk("rw_both_gnt", 32'({obs_cg, obs_hg}), 32'h3);
      core_req = 0; host_req = 0;
      #1;
      chk("rw_host_rdata", host_rdata, 32'h12345678);
      cycle();

`ifdef DMEM_ARB_FWD_EN
      // Same-address collision is forwarded
      host_req = 1; host_we = 0; host_addr = 13'h040;
      core_req = 1; core_we = 1; core_addr = 13'h040; core_wdata = 32'hCAFEF00D;
      cycle();
      core_req = 0; host_req = 0;
      #1;
      chk("fwd_host_rdata", host_rdata, 32'hCAFEF00D);
      cycle();
`endif

      // Host-only alternating write/read at the top address
      host_req = 1; host_addr = 13'h1FFF;
      for (int i = 0; i < 8; i++) begin
         host_we = ~i[0];
         if (host_we) host_wdata = $urandom;
         cycle();
         chk("host_only_gnt", 32'(obs_hg), 1);
         if (!host_we) chk("host_only_rdata", host_rdata, host_wdata);
      end
      host_req = 0;
      cycle();

      // Constrained-random traffic honouring the hold-until-grant rule
      new_core(); new_host();
      for (int i = 0; i < 400; i++) begin
         cycle();
         if (!core_req || e_cg) new_core();
         if (!host_req || e_hg) new_host();
      end

      // Build up a write wait, then reset over a granted core read
      core_req = 1; core_we = 1; core_addr = 13'h002; core_wdata = 32'h1;
      host_req = 1; host_we = 1; host_addr = 13'h003; host_wdata = 32'h2;
      cycle(); cycle();
      chk("pre_rst_wr_wait", 32'(dut.wr_wait), 2);
      host_req = 0; core_we = 0; core_addr = 13'h004;
      #1;
      chk("rst_read_gnt", 32'(core_gnt), 1);
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("inrst");
      @(posedge clock);
      #1;
      chk_reset_outputs("inrst_edge");
      @(negedge clock);
      rst_n = 1'b1;
      m_reset();
      core_req = 0;
      #1;
      chk("post_rst_core_rvalid", 32'(core_rvalid), 0);
      chk("post_rst_wr_wait", 32'(dut.wr_wait), 0);
      chk("post_rst_rd_wait", 32'(dut.rd_wait), 0);
      core_req = 1; core_we = 0; core_addr = 13'h010;
      cycle();
      core_req = 0;
      cycle();
      cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
